// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous RAM between the CPU
// memory interface and the debug/loader port; one latched request in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              gnt_cpu,
    output logic              gnt_dbg,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    state_t              state_r;
    state_t              state_nx_s;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_nx_s;
    logic                owner_dbg_r;
    logic                owner_dbg_nx_s;
    logic                last_dbg_r;
    logic                last_dbg_nx_s;
    logic                we_r;
    logic                we_nx_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_nx_s;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   wdata_nx_s;
    logic                capture_s;
    logic                pick_dbg_s;

    logic                mem_en_r;
    logic                mem_we_r;
    logic                cpu_ack_r;
    logic                dbg_ack_r;
    logic                gnt_cpu_r;
    logic                gnt_dbg_r;
    logic                busy_r;
    logic [DATA_W-1:0]   cpu_rdata_r;
    logic [DATA_W-1:0]   dbg_rdata_r;

    // Next-state, grant selection and request latching.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        owner_dbg_nx_s = owner_dbg_r;
        last_dbg_nx_s  = last_dbg_r;
        we_nx_s        = we_r;
        addr_nx_s      = addr_r;
        wdata_nx_s     = wdata_r;
        capture_s      = 1'b0;
        // On a tie the port that did not win last time is served.
        pick_dbg_s     = dbg_req & (~cpu_req | ~last_dbg_r);
        case (state_r)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_dbg_nx_s = pick_dbg_s;
                    last_dbg_nx_s  = pick_dbg_s;
                    if (pick_dbg_s) begin
                        we_nx_s    = dbg_we;
                        addr_nx_s  = dbg_addr;
                        wdata_nx_s = dbg_wdata;
                    end else begin
                        we_nx_s    = cpu_we;
                        addr_nx_s  = cpu_addr;
                        wdata_nx_s = cpu_wdata;
                    end
                    state_nx_s = ST_ACCESS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_r) begin
                    state_nx_s = ST_ACK;
                end else begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = LAT_C;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd1) begin
                    capture_s  = 1'b1;
                    cnt_nx_s   = 3'd0;
                    state_nx_s = ST_ACK;
                end else begin
                    cnt_nx_s   = cnt_r - 3'd1;
                end
            end
            ST_ACK: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control state, latched request and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            owner_dbg_r <= 1'b0;
            last_dbg_r  <= 1'b1;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            owner_dbg_r <= owner_dbg_nx_s;
            last_dbg_r  <= last_dbg_nx_s;
            we_r        <= we_nx_s;
            addr_r      <= addr_nx_s;
            wdata_r     <= wdata_nx_s;
        end
    end

    // Strobes, grants and acks are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            cpu_ack_r <= 1'b0;
            dbg_ack_r <= 1'b0;
            gnt_cpu_r <= 1'b0;
            gnt_dbg_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            mem_en_r  <= (state_nx_s == ST_ACCESS);
            mem_we_r  <= (state_nx_s == ST_ACCESS) & we_nx_s;
            cpu_ack_r <= (state_nx_s == ST_ACK) & ~owner_dbg_nx_s;
            dbg_ack_r <= (state_nx_s == ST_ACK) & owner_dbg_nx_s;
            gnt_cpu_r <= (state_nx_s != ST_IDLE) & ~owner_dbg_nx_s;
            gnt_dbg_r <= (state_nx_s != ST_IDLE) & owner_dbg_nx_s;
            busy_r    <= (state_nx_s != ST_IDLE);
        end
    end

    // Read data lands in the owner's register on the last WAIT cycle and is held until its next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_r <= {DATA_W{1'b0}};
            dbg_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (capture_s && !owner_dbg_r) begin
                cpu_rdata_r <= mem_rdata;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
            if (capture_s && owner_dbg_r) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                dbg_rdata_r <= dbg_rdata_r;
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign dbg_ack   = dbg_ack_r;
    assign gnt_cpu   = gnt_cpu_r;
    assign gnt_dbg   = gnt_dbg_r;
    assign busy      = busy_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dbg_rdata = dbg_rdata_r;

endmodule
